// File: rtl/alu_pkg.sv
// Shared ALU definitions used by the bit-field extract unit and the bit-field packer.
package alu_pkg;

  localparam int BF_WORD_W = 32;

  typedef enum logic [0:0] {
    BP_PACK = 1'b0,
    BP_TAIL = 1'b1
  } bitpack_state_t;

  // Low mask of 'width' ones; a width of 0 selects the full 32-bit word.
  function automatic logic [BF_WORD_W-1:0] bf_mask(input logic [4:0] width);
    logic [BF_WORD_W-1:0] one;
    one = {{(BF_WORD_W-1){1'b0}}, 1'b1};
    if (width == 5'd0) begin
      return '1;
    end
    return (one << width) - one;
  endfunction

endpackage

// File: rtl/bitpack32_if.sv
// Field-in / packed-word-out handshake bundle for bitpack32.
interface bitpack32_if;
  import alu_pkg::*;

  // Input field stream
  logic                 i_valid;
  logic                 o_ready;
  logic [BF_WORD_W-1:0] i_data;
  logic [4:0]           i_width;
  logic                 i_last;

  // Packed word stream
  logic                 o_valid;
  logic                 i_out_ready;
  logic [BF_WORD_W-1:0] o_word;
  logic [5:0]           o_nbits;
  logic                 o_last;

  // Producer of fields / consumer of packed words
  modport master (
    output i_valid, i_data, i_width, i_last, i_out_ready,
    input  o_ready, o_valid, o_word, o_nbits, o_last
  );

  // The packer itself
  modport slave (
    input  i_valid, i_data, i_width, i_last, i_out_ready,
    output o_ready, o_valid, o_word, o_nbits, o_last
  );

endinterface

// File: rtl/bitpack32.sv
// Sequential bit-field packer: concatenates 1..32-bit fields LSB-first into
// 32-bit words and emits them through a single registered output slot.
module bitpack32
  import alu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  bitpack32_if.slave  bus
);

  bitpack_state_t         state;
  logic [BF_WORD_W-1:0]   acc;
  logic [4:0]             cnt;

  logic                   slot_free;
  logic                   accept;
  logic [5:0]             width_m;
  logic [5:0]             n;
  logic [2*BF_WORD_W-1:0] merged;

  // The output slot can take a new word if it is empty or being drained now.
  assign slot_free   = !bus.o_valid || bus.i_out_ready;
  assign bus.o_ready = !i_rst && (state == BP_PACK) && slot_free;
  assign accept      = bus.i_valid && bus.o_ready;

  // Merge the masked field above the current fill; the upper half holds spill.
  always_comb begin
    width_m = (bus.i_width == 5'd0) ? 6'd32 : {1'b0, bus.i_width};
    merged  = {{BF_WORD_W{1'b0}}, acc}
            | ({{BF_WORD_W{1'b0}}, bus.i_data & bf_mask(bus.i_width)} << cnt);
    n       = {1'b0, cnt} + width_m;
  end

  // --- stage boundary: accumulator / FSM / output slot registers ---
  // Packing FSM with registered output slot; reset discards any pending word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= BP_PACK;
      acc         <= '0;
      cnt         <= '0;
      bus.o_valid <= 1'b0;
      bus.o_word  <= '0;
      bus.o_nbits <= '0;
      bus.o_last  <= 1'b0;
    end else begin
      if (bus.o_valid && bus.i_out_ready) begin
        bus.o_valid <= 1'b0;
      end
      case (state)
        BP_PACK: begin
          if (accept) begin
            if (n < 6'd32) begin
              if (bus.i_last) begin
                bus.o_valid <= 1'b1;
                bus.o_word  <= merged[BF_WORD_W-1:0];
                bus.o_nbits <= n;
                bus.o_last  <= 1'b1;
                acc         <= '0;
                cnt         <= '0;
              end else begin
                acc <= merged[BF_WORD_W-1:0];
                cnt <= n[4:0];
              end
            end else if (n == 6'd32) begin
              bus.o_valid <= 1'b1;
              bus.o_word  <= merged[BF_WORD_W-1:0];
              bus.o_nbits <= 6'd32;
              bus.o_last  <= bus.i_last;
              acc         <= '0;
              cnt         <= '0;
            end else begin
              // Spill: n is 33..63, so n-32 is simply n[4:0].
              bus.o_valid <= 1'b1;
              bus.o_word  <= merged[BF_WORD_W-1:0];
              bus.o_nbits <= 6'd32;
              bus.o_last  <= 1'b0;
              acc         <= merged[2*BF_WORD_W-1:BF_WORD_W];
              cnt         <= n[4:0];
              if (bus.i_last) begin
                state <= BP_TAIL;
              end
            end
          end
        end
        BP_TAIL: begin
          if (slot_free) begin
            bus.o_valid <= 1'b1;
            bus.o_word  <= acc;
            bus.o_nbits <= {1'b0, cnt};
            bus.o_last  <= 1'b1;
            acc         <= '0;
            cnt         <= '0;
            state       <= BP_PACK;
          end
        end
        default: begin
          state <= BP_PACK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitpack32.sv
// Scoreboard bench for bitpack32: driver pushes expected words, monitor pops on handshake.
module tb_bitpack32;

  typedef struct packed {
    logic [31:0] word;
    logic [5:0]  nbits;
    logic        last;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  bitpack32_if bus();

  bitpack32 dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_word(input logic [31:0] w, input logic [5:0] nb, input logic l);
    exp_t e;
    e.word  = w;
    e.nbits = nb;
    e.last  = l;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [31:0] d, input logic [4:0] w, input logic l);
    int t;
    t = 0;
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    bus.i_width = w;
    bus.i_last  = l;
    @(negedge clk);
    while (!bus.o_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.o_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=o_ready_low required=accept_within_50");
    end
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  // Monitor: compare every word the DUT hands off against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (!rst && bus.o_valid && bus.i_out_ready) begin
      a.word  = bus.o_word;
      a.nbits = bus.o_nbits;
      a.last  = bus.o_last;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual=%0h required=none", a);
      end else begin
        e = exp_q.pop_front();
        chk("out_word", {25'd0, a}, {25'd0, e});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_data = '0;
    bus.i_width = '0;
    bus.i_last = 1'b0;
    bus.i_out_ready = 1'b1;

    // Reset: held two cycles
    @(posedge clk);
    @(negedge clk);
    chk("rst_o_ready", {63'd0, bus.o_ready}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_o_valid", {63'd0, bus.o_valid}, 64'd0);
    chk("rst_o_word", {32'd0, bus.o_word}, 64'd0);
    chk("rst_o_nbits", {58'd0, bus.o_nbits}, 64'd0);
    chk("rst_o_ready_after", {63'd0, bus.o_ready}, 64'd1);
    @(posedge clk);
    #1;

    // Four bytes into one word
    expect_word(32'h44332211, 6'd32, 1'b1);
    send(32'h11, 5'd8, 1'b0);
    send(32'h22, 5'd8, 1'b0);
    send(32'h33, 5'd8, 1'b0);
    send(32'h44, 5'd8, 1'b1);
    @(negedge clk);
    chk("bytes_latency_valid", {63'd0, bus.o_valid}, 64'd1);
    @(posedge clk);
    #1;

    // Overflow into a tail word
    expect_word(32'h345ABCDE, 6'd32, 1'b0);
    expect_word(32'h00000012, 6'd8, 1'b1);
    send(32'h000ABCDE, 5'd20, 1'b0);
    send(32'h00012345, 5'd20, 1'b1);
    @(negedge clk);
    chk("tail_o_ready_low", {63'd0, bus.o_ready}, 64'd0);
    @(negedge clk);
    chk("tail_o_ready_back", {63'd0, bus.o_ready}, 64'd1);
    chk("tail_o_nbits", {58'd0, bus.o_nbits}, 64'd8);
    @(posedge clk);
    #1;

    // Masking of upper data bits and width 0 as 32
    expect_word(32'hEADBEEF5, 6'd32, 1'b0);
    expect_word(32'h0000000D, 6'd4, 1'b1);
    send(32'hFFFFFFF5, 5'd4, 1'b0);
    send(32'hDEADBEEF, 5'd0, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: three full-width beats, downstream stalled for 3 cycles
    expect_word(32'hA1A1A1A1, 6'd32, 1'b0);
    expect_word(32'hA2A2A2A2, 6'd32, 1'b0);
    expect_word(32'hA3A3A3A3, 6'd32, 1'b1);
    bus.i_out_ready = 1'b0;
    send(32'hA1A1A1A1, 5'd0, 1'b0);
    bus.i_valid = 1'b1;
    bus.i_data  = 32'hA2A2A2A2;
    bus.i_width = 5'd0;
    bus.i_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_o_ready_low", {63'd0, bus.o_ready}, 64'd0);
      chk("bp_word_held", {32'd0, bus.o_word}, {32'd0, 32'hA1A1A1A1});
    end
    @(posedge clk);
    #1;
    bus.i_out_ready = 1'b1;
    send(32'hA2A2A2A2, 5'd0, 1'b0);
    send(32'hA3A3A3A3, 5'd0, 1'b1);
    @(negedge clk);
    chk("bp_last_valid", {63'd0, bus.o_valid}, 64'd1);
    @(posedge clk);
    #1;

    // Reset while in TAIL: pending and tail words are discarded
    send(32'h000ABCDE, 5'd20, 1'b0);
    send(32'h00012345, 5'd20, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_tail_no_word", {63'd0, bus.o_valid}, 64'd0);
    end
    @(posedge clk);
    #1;
    expect_word(32'h00000007, 6'd3, 1'b1);
    send(32'h00000007, 5'd3, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
